// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB write-back stage: default widths,
// write-back source select encodings and load funct3 encodings.
package mem_wb_stage_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_RAM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Handshake and data bundle between EX_MEM, the MEM/WB stage and the
// register file. The stage itself connects through the slave modport.
interface mem_wb_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  validIn;
   logic                  readyOut;
   logic [1:0]            wbSelIn;
   logic [XLEN-1:0]       dataFromALU;
   logic [XLEN-1:0]       dataFromRam;
   logic [XLEN-1:0]       pcPlus4In;
   logic [XLEN-1:0]       immIn;
   logic [2:0]            loadFunct3In;
   logic [1:0]            byteOffsetIn;
   logic                  writeEnableIn;
   logic [REG_ADDR_W-1:0] writeBackAddrIn;
   logic                  flushIn;
   logic                  readyIn;
   logic                  validOut;
   logic                  writeEnableOut;
   logic [REG_ADDR_W-1:0] writeBackAddrOut;
   logic [XLEN-1:0]       dataToReg;

   modport master (
      output validIn, wbSelIn, dataFromALU, dataFromRam, pcPlus4In, immIn,
             loadFunct3In, byteOffsetIn, writeEnableIn, writeBackAddrIn,
             flushIn, readyIn,
      input  readyOut, validOut, writeEnableOut, writeBackAddrOut, dataToReg
   );

   modport slave (
      input  validIn, wbSelIn, dataFromALU, dataFromRam, pcPlus4In, immIn,
             loadFunct3In, byteOffsetIn, writeEnableIn, writeBackAddrIn,
             flushIn, readyIn,
      output readyOut, validOut, writeEnableOut, writeBackAddrOut, dataToReg
   );
endinterface

// File: rtl/mem_wb_stage_wb_load_align.sv
// Combinational load extraction: picks the byte/halfword addressed by the
// low address bits and sign- or zero-extends it according to funct3.
module wb_load_align
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] word,
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] byte_sh;
   logic [XLEN-1:0] half_sh;

   // Halfwords only shift by 0 or 16: odd offsets round down.
   assign byte_sh = word >> {offset, 3'b000};
   assign half_sh = word >> {offset[1], 4'b0000};

   always_comb begin
      data = word;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
         F3_LH:   data = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sh[15:0]};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: one main register plus one skid entry with a
// registered readyOut. Load byte/half extraction is built when WB_LOAD_EXT_EN is defined.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input logic           clk,
   input logic           resetIn,
   mem_wb_stage_if.slave bus
);

   logic [XLEN-1:0]       ram_val_p0;
   logic [XLEN-1:0]       wb_data_p0;
   logic                  we_p0;
   logic                  accept_p0;

   logic                  vld_p1;
   logic                  we_p1;
   logic [REG_ADDR_W-1:0] addr_p1;
   logic [XLEN-1:0]       data_p1;

   logic                  vld_sk;
   logic                  we_sk;
   logic [REG_ADDR_W-1:0] addr_sk;
   logic [XLEN-1:0]       data_sk;

   logic                  rdy_q;
   logic                  drain;
   logic                  main_free;
   logic                  load_skid;

`ifdef WB_LOAD_EXT_EN
   wb_load_align #(.XLEN(XLEN)) u_load_align (
      .word   (bus.dataFromRam),
      .funct3 (bus.loadFunct3In),
      .offset (bus.byteOffsetIn),
      .data   (ram_val_p0)
   );
`else
   logic unused_ld_ctrl;
   assign unused_ld_ctrl = ^{bus.loadFunct3In, bus.byteOffsetIn};
   assign ram_val_p0     = bus.dataFromRam;
`endif

   // Stage p0: resolve the write-back value and x0 suppression at input time
   always_comb begin
      wb_data_p0 = bus.dataFromALU;
      case (bus.wbSelIn)
         WB_ALU:  wb_data_p0 = bus.dataFromALU;
         WB_RAM:  wb_data_p0 = ram_val_p0;
         WB_PC4:  wb_data_p0 = bus.pcPlus4In;
         WB_IMM:  wb_data_p0 = bus.immIn;
         default: wb_data_p0 = bus.dataFromALU;
      endcase
   end

   assign we_p0     = bus.writeEnableIn && (bus.writeBackAddrIn != '0);
   assign accept_p0 = bus.validIn && rdy_q && !bus.flushIn;
   assign drain     = vld_p1 && bus.readyIn;
   assign main_free = !vld_p1 || drain;
   assign load_skid = accept_p0 && !main_free;

   // Stage p1: main register and skid control
   always_ff @(posedge clk) begin
      if (resetIn) begin
         vld_p1  <= 1'b0;
         we_p1   <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         vld_sk  <= 1'b0;
         rdy_q   <= 1'b1;
      end else if (bus.flushIn) begin
         vld_p1 <= 1'b0;
         vld_sk <= 1'b0;
         rdy_q  <= 1'b1;
      end else if (main_free) begin
         // readyOut low means skid is full, so accept and skid refill never coincide
         if (vld_sk) begin
            vld_p1  <= 1'b1;
            we_p1   <= we_sk;
            addr_p1 <= addr_sk;
            data_p1 <= data_sk;
            vld_sk  <= 1'b0;
            rdy_q   <= 1'b1;
         end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
               we_p1   <= we_p0;
               addr_p1 <= bus.writeBackAddrIn;
               data_p1 <= wb_data_p0;
            end
         end
      end else if (accept_p0) begin
         vld_sk <= 1'b1;
         rdy_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) begin
         we_sk   <= we_p0;
         addr_sk <= bus.writeBackAddrIn;
         data_sk <= wb_data_p0;
      end
   end

   assign bus.readyOut         = rdy_q;
   assign bus.validOut         = vld_p1;
   assign bus.writeEnableOut   = vld_p1 && we_p1;
   assign bus.writeBackAddrOut = addr_p1;
   assign bus.dataToReg        = data_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; the load-extension test is built
// when WB_LOAD_EXT_EN is defined, otherwise raw RAM pass-through is checked.
module tb_mem_wb_stage;

   logic clk;
   logic resetIn;
   int   checks;
   int   failures;

   mem_wb_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

   mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk     (clk),
      .resetIn (resetIn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.validIn         = 1'b0;
      bus.wbSelIn         = 2'd0;
      bus.dataFromALU     = '0;
      bus.dataFromRam     = '0;
      bus.pcPlus4In       = '0;
      bus.immIn           = '0;
      bus.loadFunct3In    = 3'b010;
      bus.byteOffsetIn    = 2'd0;
      bus.writeEnableIn   = 1'b0;
      bus.writeBackAddrIn = '0;
      bus.flushIn         = 1'b0;
   endtask

   task automatic beat(input logic [1:0] sel, input logic [31:0] val,
                       input logic we, input logic [4:0] addr);
      bus.validIn         = 1'b1;
      bus.wbSelIn         = sel;
      bus.dataFromALU     = (sel == 2'd0) ? val : 32'hDEAD0000;
      bus.dataFromRam     = (sel == 2'd1) ? val : 32'hDEAD0001;
      bus.pcPlus4In       = (sel == 2'd2) ? val : 32'hDEAD0002;
      bus.immIn           = (sel == 2'd3) ? val : 32'hDEAD0003;
      bus.writeEnableIn   = we;
      bus.writeBackAddrIn = addr;
   endtask

   task automatic test_reset();
      idle();
      bus.readyIn = 1'b0;
      resetIn = 1'b1;
      step();
      resetIn = 1'b0;
      checks++; if (bus.validOut !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.validOut); end
      checks++; if (bus.writeEnableOut !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.writeEnableOut); end
      checks++; if (bus.writeBackAddrOut !== 5'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.writeBackAddrOut); end
      checks++; if (bus.dataToReg !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.dataToReg); end
      checks++; if (bus.readyOut !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.readyOut); end
   endtask

   task automatic test_alu();
      bus.readyIn = 1'b1;
      beat(2'd0, 32'h12345678, 1'b1, 5'd5);
      step();
      idle();
      checks++; if (bus.validOut !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", bus.validOut); end
      checks++; if (bus.dataToReg !== 32'h12345678) begin failures++; $display("FAIL alu_data got=%h exp=12345678", bus.dataToReg); end
      checks++; if (bus.writeEnableOut !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", bus.writeEnableOut); end
      checks++; if (bus.writeBackAddrOut !== 5'd5) begin failures++; $display("FAIL alu_addr got=%h exp=05", bus.writeBackAddrOut); end
      step();
      checks++; if (bus.validOut !== 1'b0) begin failures++; $display("FAIL alu_drained got=%b exp=0", bus.validOut); end
      checks++; if (bus.writeEnableOut !== 1'b0) begin failures++; $display("FAIL alu_we_idle got=%b exp=0", bus.writeEnableOut); end
   endtask

   task automatic test_sel_back_to_back();
      bus.readyIn = 1'b1;
      beat(2'd2, 32'h00000104, 1'b1, 5'd1);
      step();
      checks++; if (bus.dataToReg !== 32'h00000104) begin failures++; $display("FAIL sel_pc4 got=%h exp=00000104", bus.dataToReg); end
      beat(2'd3, 32'h00000ABC, 1'b1, 5'd2);
      step();
      checks++; if (bus.validOut !== 1'b1 || bus.dataToReg !== 32'h00000ABC) begin failures++; $display("FAIL sel_imm got=%b/%h exp=1/00000abc", bus.validOut, bus.dataToReg); end
      beat(2'd1, 32'h80FF7F01, 1'b1, 5'd3);
      bus.loadFunct3In = 3'b000;
      bus.byteOffsetIn = 2'd1;
      step();
`ifdef WB_LOAD_EXT_EN
      checks++; if (bus.dataToReg !== 32'h0000007F) begin failures++; $display("FAIL sel_ram_lb got=%h exp=0000007f", bus.dataToReg); end
`else
      checks++; if (bus.dataToReg !== 32'h80FF7F01) begin failures++; $display("FAIL sel_ram_raw got=%h exp=80ff7f01", bus.dataToReg); end
`endif
      idle();
      step();
      checks++; if (bus.validOut !== 1'b0) begin failures++; $display("FAIL sel_drained got=%b exp=0", bus.validOut); end
   endtask

`ifdef WB_LOAD_EXT_EN
   task automatic test_load_ext();
      bus.readyIn = 1'b1;
      beat(2'd1, 32'h80FF7F01, 1'b1, 5'd4);
      bus.loadFunct3In = 3'b000;
      bus.byteOffsetIn = 2'd2;
      step();
      checks++; if (bus.dataToReg !== 32'hFFFFFFFF) begin failures++; $display("FAIL ld_lb_off2 got=%h exp=ffffffff", bus.dataToReg); end
      bus.loadFunct3In = 3'b101;
      step();
      checks++; if (bus.dataToReg !== 32'h000080FF) begin failures++; $display("FAIL ld_lhu_off2 got=%h exp=000080ff", bus.dataToReg); end
      bus.loadFunct3In = 3'b001;
      bus.byteOffsetIn = 2'd1;
      step();
      checks++; if (bus.dataToReg !== 32'h00007F01) begin failures++; $display("FAIL ld_lh_off1 got=%h exp=00007f01", bus.dataToReg); end
      idle();
      step();
   endtask
`endif

   task automatic test_x0();
      bus.readyIn = 1'b1;
      beat(2'd0, 32'h0000BEEF, 1'b1, 5'd0);
      step();
      checks++; if (bus.validOut !== 1'b1 || bus.writeEnableOut !== 1'b0) begin failures++; $display("FAIL x0_write got=%b/%b exp=1/0", bus.validOut, bus.writeEnableOut); end
      beat(2'd0, 32'h0000CAFE, 1'b0, 5'd7);
      step();
      checks++; if (bus.writeEnableOut !== 1'b0 || bus.writeBackAddrOut !== 5'd7) begin failures++; $display("FAIL we0_write got=%b/%h exp=0/07", bus.writeEnableOut, bus.writeBackAddrOut); end
      idle();
      step();
   endtask

   task automatic test_stall();
      bus.readyIn = 1'b0;
      beat(2'd0, 32'hAAAA0001, 1'b1, 5'd10);
      step();
      checks++; if (bus.dataToReg !== 32'hAAAA0001 || bus.readyOut !== 1'b1) begin failures++; $display("FAIL stall_a_held got=%h/%b exp=aaaa0001/1", bus.dataToReg, bus.readyOut); end
      beat(2'd0, 32'hBBBB0002, 1'b1, 5'd11);
      step();
      checks++; if (bus.dataToReg !== 32'hAAAA0001 || bus.readyOut !== 1'b0) begin failures++; $display("FAIL stall_b_skid got=%h/%b exp=aaaa0001/0", bus.dataToReg, bus.readyOut); end
      beat(2'd0, 32'hCCCC0003, 1'b1, 5'd12);
      step();
      checks++; if (bus.dataToReg !== 32'hAAAA0001 || bus.readyOut !== 1'b0 || bus.validOut !== 1'b1) begin failures++; $display("FAIL stall_c_blocked got=%h/%b/%b exp=aaaa0001/0/1", bus.dataToReg, bus.readyOut, bus.validOut); end
      bus.readyIn = 1'b1;
      step();
      checks++; if (bus.dataToReg !== 32'hBBBB0002 || bus.writeBackAddrOut !== 5'd11 || bus.readyOut !== 1'b1) begin failures++; $display("FAIL stall_b_out got=%h/%h/%b exp=bbbb0002/0b/1", bus.dataToReg, bus.writeBackAddrOut, bus.readyOut); end
      step();
      idle();
      checks++; if (bus.dataToReg !== 32'hCCCC0003 || bus.writeBackAddrOut !== 5'd12 || bus.validOut !== 1'b1) begin failures++; $display("FAIL stall_c_out got=%h/%h/%b exp=cccc0003/0c/1", bus.dataToReg, bus.writeBackAddrOut, bus.validOut); end
      step();
      checks++; if (bus.validOut !== 1'b0) begin failures++; $display("FAIL stall_no_dup got=%b exp=0", bus.validOut); end
   endtask

   task automatic test_flush();
      bus.readyIn = 1'b0;
      beat(2'd0, 32'h11110001, 1'b1, 5'd13);
      step();
      beat(2'd0, 32'h22220002, 1'b1, 5'd14);
      step();
      checks++; if (bus.readyOut !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", bus.readyOut); end
      beat(2'd0, 32'h33330003, 1'b1, 5'd15);
      bus.flushIn = 1'b1;
      step();
      idle();
      checks++; if (bus.validOut !== 1'b0 || bus.readyOut !== 1'b1 || bus.writeEnableOut !== 1'b0) begin failures++; $display("FAIL flush_clear got=%b/%b/%b exp=0/1/0", bus.validOut, bus.readyOut, bus.writeEnableOut); end
      bus.readyIn = 1'b1;
      step();
      checks++; if (bus.validOut !== 1'b0) begin failures++; $display("FAIL flush_no_emit got=%b exp=0", bus.validOut); end
   endtask

   task automatic test_reset_midstall();
      bus.readyIn = 1'b0;
      beat(2'd0, 32'h44440001, 1'b1, 5'd16);
      step();
      beat(2'd0, 32'h55550002, 1'b1, 5'd17);
      step();
      resetIn = 1'b1;
      bus.flushIn = 1'b1;
      step();
      resetIn = 1'b0;
      idle();
      checks++; if (bus.validOut !== 1'b0 || bus.writeEnableOut !== 1'b0 || bus.writeBackAddrOut !== 5'd0 || bus.dataToReg !== 32'h0) begin failures++; $display("FAIL rst_stall_zero got=%b/%b/%h/%h exp=0/0/00/00000000", bus.validOut, bus.writeEnableOut, bus.writeBackAddrOut, bus.dataToReg); end
      checks++; if (bus.readyOut !== 1'b1) begin failures++; $display("FAIL rst_stall_ready got=%b exp=1", bus.readyOut); end
      bus.readyIn = 1'b1;
      beat(2'd0, 32'h66660003, 1'b1, 5'd18);
      step();
      idle();
      checks++; if (bus.validOut !== 1'b1 || bus.dataToReg !== 32'h66660003 || bus.writeBackAddrOut !== 5'd18) begin failures++; $display("FAIL rst_stall_first got=%b/%h/%h exp=1/66660003/12", bus.validOut, bus.dataToReg, bus.writeBackAddrOut); end
      step();
      checks++; if (bus.validOut !== 1'b0) begin failures++; $display("FAIL rst_stall_lost got=%b exp=0", bus.validOut); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetIn  = 1'b1;
      bus.readyIn = 1'b0;
      idle();
      test_reset();
      test_alu();
      test_sel_back_to_back();
`ifdef WB_LOAD_EXT_EN
      test_load_ext();
`endif
      test_x0();
      test_stall();
      test_flush();
      test_reset_midstall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the write-back path.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port resetIn  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port validIn  in  1  upstream (EX_MEM side) beat valid.
REQ-006 SHALL have port readyOut  out  1  stage can accept a beat; driven directly from a flop.
REQ-007 SHALL have port wbSelIn  in  2  write-back source: 0 ALU, 1 RAM, 2 PC+4, 3 immediate.
REQ-008 SHALL have ports dataFromALU, dataFromRam, pcPlus4In, immIn  in  XLEN  candidate write-back values.
REQ-009 SHALL have port loadFunct3In  in  3  load type: LB, LH, LW, LBU, LHU encodings.
REQ-010 SHALL have port byteOffsetIn  in  2  low address bits of the load.
REQ-011 SHALL have ports writeEnableIn (1) and writeBackAddrIn (REG_ADDR_W), both in  destination control.
REQ-012 SHALL have port flushIn  in  1  discard all held beats.
REQ-013 SHALL have port readyIn  in  1  register-file side accepts.
REQ-014 SHALL have port validOut  out  1  output beat valid.
REQ-015 SHALL have ports writeEnableOut (1), writeBackAddrOut (REG_ADDR_W) and dataToReg (XLEN), all out  write-back beat.

Function
REQ-016 SHALL transfer a beat in when validIn && readyOut, and out when validOut && readyIn.
REQ-017 SHALL hold a main register plus one skid entry: two beats maximum.
REQ-018 SHALL give 1-cycle latency from accepted input to validOut when the stage is empty.
REQ-019 SHALL divert an accepted beat into the skid entry when main is valid and readyIn=0.
REQ-020 SHALL move the skid entry into main on the cycle main drains; skid empties simultaneously.
REQ-021 SHALL deassert readyOut on the cycle after the skid entry fills, and reassert it on the cycle after it drains.
REQ-022 SHALL, on simultaneous drain and accept with an empty skid, load the new beat into main with no bubble.
REQ-023 SHALL resolve the selected source at input time; the mux result is stored, not the raw inputs.
REQ-024 SHALL force writeEnableOut=0 whenever writeBackAddrOut==0 (x0 writes suppressed).
REQ-025 SHALL hold writeEnableOut at 0 whenever validOut=0.
REQ-026 SHALL, on flushIn, clear both valid bits on the next edge and ignore a concurrent input beat; flush has priority over accept.
REQ-027 SHALL keep outputs stable while validOut && !readyIn.

Reset
REQ-028 SHALL give the following values on resetIn: validOut=0, writeEnableOut=0, writeBackAddrOut=0, dataToReg=0, skid empty, readyOut=1 on the next cycle.
REQ-029 SHALL let resetIn win over flushIn and any handshake, including mid-stall; any held beats are lost.

Configuration
REQ-030 SHALL, when WB_LOAD_EXT_EN is defined, extract the RAM source by byteOffsetIn/loadFunct3In: LB/LH sign-extend, LBU/LHU zero-extend, LW passes; misaligned LH (offset 1 or 3) uses bits [15:0] of the word shifted by offset rounded down to 2.
REQ-031 SHALL, without WB_LOAD_EXT_EN, pass dataFromRam unmodified and leave loadFunct3In/byteOffsetIn unused.

Structure
REQ-032 SHALL define XLEN and REG_ADDR_W defaults, the wbSel encodings and the load funct3 encodings as constants in the shared define package.
REQ-033 SHALL place load extraction in a combinational sub-module wb_load_align, instantiated only under WB_LOAD_EXT_EN.

Verification
REQ-034 SHALL cover: wbSel=0, ALU=0x12345678, addr=5, readyIn=1 -> next cycle validOut=1, dataToReg=0x12345678, writeEnableOut=1.
REQ-035 SHALL cover, with WB_LOAD_EXT_EN: LB, RAM=0x80FF7F01, offset=1 -> 0x0000007F; offset=2 -> 0xFFFFFFFF; LHU offset=2 -> 0x000080FF.
REQ-036 SHALL cover: readyIn=0 for 3 cycles with back-to-back beats A, B, C -> A held, B in skid, readyOut=0, C not accepted; after release, A then B then C with no loss or duplication.
REQ-037 SHALL cover: a write to addr=0 with writeEnableIn=1 -> writeEnableOut=0, validOut=1.
REQ-038 SHALL cover: flushIn with both entries full and validIn=1 -> next cycle validOut=0 and readyOut=1, and no beat is emitted.
REQ-039 SHALL cover: resetIn asserted mid-stall -> all outputs zero on the next edge, and the first beat accepted after reset emerges correctly.
